// File: rtl/data_memory_if.sv
// Memory-stage bus for the Y86-64 data memory: address, write request/data and read-back/status.
interface data_memory_if;
  logic        [63:0] address;
  logic               write_enable;
  logic signed [63:0] data_in;
  logic signed [63:0] data_out;
  logic               dmem_error;

  modport master (
    output address,
    output write_enable,
    output data_in,
    input  data_out,
    input  dmem_error
  );

  modport slave (
    input  address,
    input  write_enable,
    input  data_in,
    output data_out,
    output dmem_error
  );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed 64-bit little-endian data memory: combinational read, falling-edge write.
// Optional macro DMEM_ALIGN_CHECK_EN also flags accesses whose address[2:0] is non-zero.
module data_memory #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic          w_err;
  logic [AW-1:0] w_base;
  logic [63:0]   w_rdata;

  // Full 64-bit unsigned compare so huge addresses never wrap into range.
  always_comb begin
    w_err = (bus.address > 64'(DEPTH - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    w_err = w_err | (bus.address[2:0] != 3'b000);
`else
    w_err = w_err;
`endif
  end

  assign w_base = bus.address[AW-1:0];

  always_comb begin
    w_rdata = '0;
    if (!w_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        w_rdata[8*i +: 8] = r_mem[w_base + AW'(i)];
      end
    end
  end

  assign bus.data_out   = w_rdata;
  assign bus.dmem_error = w_err;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.write_enable && !w_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_mem[w_base + AW'(i)] <= bus.data_in[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, writes, dropped writes, range limits, overlap, async reset.
module tb_data_memory;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  data_memory_if bus ();

  data_memory #(.DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs applied just after a falling edge, held through the next falling edge.
  task automatic mem_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    #1;
    bus.address      = a;
    bus.data_in      = d;
    bus.write_enable = 1'b1;
    @(negedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [63:0] a, input logic [63:0] exp,
                          input logic exp_err);
    @(negedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.address      = a;
    #1;
    check_val({tag, "_data"}, bus.data_out, exp);
    check_val({tag, "_err"}, 64'(bus.dmem_error), 64'(exp_err));
  endtask

  initial begin
    n_vec            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    bus.address      = 64'd10;
    bus.data_in      = 64'd0;
    bus.write_enable = 1'b0;
    #1;
    check_val("reset_data", bus.data_out, 64'd0);
    check_val("reset_err", 64'(bus.dmem_error), 64'd0);
    bus.address = 64'd1017;
    #1;
    check_val("reset_range_err", 64'(bus.dmem_error), 64'd1);
    #21;
    rst_n = 1'b1;

    mem_write(64'd10, 64'd100);
    mem_read("rd10", 64'd10, 64'd100, 1'b0);

    // Write request present only across the rising edge: must not commit.
    @(negedge clk);
    #1;
    bus.address      = 64'd19;
    bus.data_in      = 64'd10;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    @(negedge clk);
    #1;
    check_val("drop19", bus.data_out, 64'd0);

    mem_write(64'd19, 64'd10);
    mem_read("rd19", 64'd19, 64'd10, 1'b0);
    mem_read("rd10_again", 64'd10, 64'd100, 1'b0);

    // Read-before-write at 96.
    @(negedge clk);
    #1;
    bus.address      = 64'd96;
    bus.data_in      = 64'd90;
    bus.write_enable = 1'b0;
    #1;
    check_val("rbw_idle", bus.data_out, 64'd0);
    bus.write_enable = 1'b1;
    #1;
    check_val("rbw_pre_rise", bus.data_out, 64'd0);
    @(posedge clk);
    #1;
    check_val("rbw_post_rise", bus.data_out, 64'd0);
    @(negedge clk);
    #1;
    check_val("rbw_post_fall", bus.data_out, 64'd90);
    bus.write_enable = 1'b0;

    mem_write(64'd96, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_read("neg1", 64'd96, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Upper boundary.
    mem_write(64'd1016, 64'hDEAD_BEEF_0123_4567);
    mem_read("b1016", 64'd1016, 64'hDEAD_BEEF_0123_4567, 1'b0);
    mem_read("b1017", 64'd1017, 64'd0, 1'b1);
    mem_write(64'd1017, 64'h5555_5555_5555_5555);
    mem_read("b1016_kept", 64'd1016, 64'hDEAD_BEEF_0123_4567, 1'b0);
    mem_read("huge", 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1);

    // Unaligned overlap.
    mem_write(64'd0, 64'h1122_3344_5566_7788);
    mem_write(64'd4, 64'h0000_0000_0000_00AA);
`ifdef DMEM_ALIGN_CHECK_EN
    mem_read("ovl_a4", 64'd4, 64'd0, 1'b1);
    mem_read("ovl_a0", 64'd0, 64'h1122_3344_5566_7788, 1'b0);
`else
    mem_read("ovl_a4", 64'd4, 64'h0000_0000_0000_00AA, 1'b0);
    mem_read("ovl_a0", 64'd0, 64'h0000_00AA_5566_7788, 1'b0);
`endif

    // Asynchronous reset mid-cycle with a write pending.
    mem_write(64'd10, 64'd100);
    mem_read("pre_rst", 64'd10, 64'd100, 1'b0);
    bus.data_in      = 64'd777;
    bus.write_enable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", bus.data_out, 64'd0);
    @(negedge clk);
    #1;
    check_val("rst_hold", bus.data_out, 64'd0);
    bus.write_enable = 1'b0;
    #1;
    rst_n = 1'b1;
    mem_read("post_rst", 64'd10, 64'd0, 1'b0);
    mem_read("post_rst96", 64'd96, 64'd0, 1'b0);
    mem_write(64'd10, 64'd42);
    mem_read("first_wr", 64'd10, 64'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
